// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one 32-bit ALU between two requesters,
// steering the operand muxes, waiting out the ALU settle time and returning the result.
module alu_share_arbiter #(
   parameter int LATENCY = 2,
   parameter int OPW     = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   input  logic [OPW-1:0] req0_op,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [OPW-1:0] req1_op,
   output logic           req1_ready,
   output logic           mux_ctl,
   output logic [OPW-1:0] alu_op,
   input  logic [31:0]    alu_result,
   output logic           rsp_valid,
   output logic           rsp_id,
   output logic [31:0]    rsp_data,
   output logic           busy
);

   // Handshake: a requester holds valid, op and its operands stable until the
   // cycle its ready pulses; ready and rsp_valid are the same one-cycle event.
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int CW = 4;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ptr_q, ptr_d;
   logic           gnt;
   logic           ctl_d;
   logic [OPW-1:0] op_d;
   logic           rv_d, rid_d, r0_d, r1_d, busy_d;
   logic [31:0]    rdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt     = 1'b0;
      ctl_d   = mux_ctl;
      op_d    = alu_op;
      rv_d    = 1'b0;
      rid_d   = rsp_id;
      rdata_d = rsp_data;
      r0_d    = 1'b0;
      r1_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // With no request the select is left alone so the muxes never toggle needlessly.
            if (req0_valid || req1_valid) begin
               gnt     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
               ctl_d   = gnt;
               op_d    = gnt ? req1_op : req0_op;
               cnt_d   = CW'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               rdata_d = alu_result;
               rid_d   = mux_ctl;
               rv_d    = 1'b1;
               r0_d    = ~mux_ctl;
               r1_d    = mux_ctl;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            ptr_d   = ~rsp_id;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= 1'b0;
         mux_ctl    <= 1'b0;
         alu_op     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         mux_ctl    <= ctl_d;
         alu_op     <= op_d;
         rsp_valid  <= rv_d;
         rsp_id     <= rid_d;
         rsp_data   <= rdata_d;
         req0_ready <= r0_d;
         req1_ready <= r1_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a LATENCY=2 instance for most scenarios
// and a LATENCY=1 instance for the short settle case.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   // LATENCY=2 instance
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [2:0]  req0_op = '0, req1_op = '0;
   logic        req0_ready, req1_ready, mux_ctl, rsp_valid, rsp_id, busy;
   logic [2:0]  alu_op;
   logic [31:0] alu_result, rsp_data;
   logic [31:0] a0 = '0, a1 = '0;

   // LATENCY=1 instance
   logic        l_req0_valid = 1'b0, l_req1_valid = 1'b0;
   logic [2:0]  l_req0_op = '0, l_req1_op = '0;
   logic        l_req0_ready, l_req1_ready, l_mux_ctl, l_rsp_valid, l_rsp_id, l_busy;
   logic [2:0]  l_alu_op;
   logic [31:0] l_alu_result, l_rsp_data;
   logic [31:0] l_a0 = '0, l_a1 = '0;

   // Operand muxes feeding a pass-through ALU.
   assign alu_result   = mux_ctl ? a1 : a0;
   assign l_alu_result = l_mux_ctl ? l_a1 : l_a0;

   alu_share_arbiter #(.LATENCY(2), .OPW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
      .mux_ctl(mux_ctl), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   alu_share_arbiter #(.LATENCY(1), .OPW(3)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(l_req0_valid), .req0_op(l_req0_op), .req0_ready(l_req0_ready),
      .req1_valid(l_req1_valid), .req1_op(l_req1_op), .req1_ready(l_req1_ready),
      .mux_ctl(l_mux_ctl), .alu_op(l_alu_op), .alu_result(l_alu_result),
      .rsp_valid(l_rsp_valid), .rsp_id(l_rsp_id), .rsp_data(l_rsp_data), .busy(l_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ready exclusivity and rsp_valid/ready agreement, every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("excl", {31'd0, req0_ready & req1_ready}, 32'd0);
         chk("rv_eq_rdy", {31'd0, rsp_valid}, {31'd0, req0_ready | req1_ready});
         chk("l_rv_eq_rdy", {31'd0, l_rsp_valid}, {31'd0, l_req0_ready | l_req1_ready});
      end
   end

   initial begin
      int  last;
      bit  seen;
      logic exp_id;

      // ---------------- reset values
      tick(); tick();
      chk("rst_ctl", {31'd0, mux_ctl}, 32'd0);
      chk("rst_op", {29'd0, alu_op}, 32'd0);
      chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- single req0 op, LATENCY=2
      req0_valid = 1'b1; req0_op = 3'd3; a0 = 32'h0000_00AA;
      tick();
      chk("t1_ctl", {31'd0, mux_ctl}, 32'd0);
      chk("t1_op", {29'd0, alu_op}, 32'd3);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_rdy_c1", {31'd0, req0_ready}, 32'd0);
      tick();
      chk("t1_rv_c2", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("t1_rdy0", {31'd0, req0_ready}, 32'd1);
      chk("t1_rdy1", {31'd0, req1_ready}, 32'd0);
      chk("t1_rv", {31'd0, rsp_valid}, 32'd1);
      chk("t1_id", {31'd0, rsp_id}, 32'd0);
      chk("t1_data", rsp_data, 32'h0000_00AA);
      req0_valid = 1'b0;
      tick();
      chk("t1_busy_c4", {31'd0, busy}, 32'd0);
      chk("t1_rv_c4", {31'd0, rsp_valid}, 32'd0);

      // ---------------- contention: strict alternation from pointer 0
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      req0_valid = 1'b1; req0_op = 3'd1; a0 = 32'h100;
      req1_valid = 1'b1; req1_op = 3'd2; a1 = 32'h200;
      for (int k = 0; k < 6; k++) begin
         exp_id = k[0];
         seen = 1'b0;
         for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (req0_ready || req1_ready) seen = 1'b1;
            else if (busy) chk("t2_ctl_hold", {31'd0, mux_ctl}, {31'd0, exp_id});
         end
         chk("t2_timeout", {31'd0, seen}, 32'd1);
         chk("t2_id", {31'd0, rsp_id}, {31'd0, exp_id});
         chk("t2_rdy", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
         chk("t2_data", rsp_data, exp_id ? 32'h200 : 32'h100);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // ---------------- lone req1, back-to-back, pointer 0
      req1_valid = 1'b1; req1_op = 3'd6; a1 = 32'h300;
      last = 0;
      for (int k = 0; k < 3; k++) begin
         seen = 1'b0;
         for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            chk("t3_ctl", {31'd0, mux_ctl}, 32'd1);
            if (req1_ready || req0_ready) seen = 1'b1;
         end
         chk("t3_timeout", {31'd0, seen}, 32'd1);
         chk("t3_rdy1", {31'd0, req1_ready}, 32'd1);
         chk("t3_data", rsp_data, 32'h300);
         if (k > 0) chk("t3_spacing", cyc - last, 32'd4);
         last = cyc;
      end
      req1_valid = 1'b0;
      tick();

      // ---------------- reset during BUSY
      req1_valid = 1'b1; req1_op = 3'd5; a1 = 32'h400;
      tick();
      chk("t4_ctl_pre", {31'd0, mux_ctl}, 32'd1);
      chk("t4_op_pre", {29'd0, alu_op}, 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_ctl", {31'd0, mux_ctl}, 32'd0);
      chk("t4_op", {29'd0, alu_op}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_rv", {31'd0, rsp_valid}, 32'd0);
      chk("t4_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      req1_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("t4_idle", {31'd0, busy}, 32'd0);
      end
      req0_valid = 1'b1; req0_op = 3'd7; a0 = 32'h700;
      req1_valid = 1'b1; req1_op = 3'd1;
      tick();
      chk("t4_ptr0", {31'd0, mux_ctl}, 32'd0);
      chk("t4_op7", {29'd0, alu_op}, 32'd7);
      tick(); tick();
      chk("t4_rdy0", {31'd0, req0_ready}, 32'd1);
      chk("t4_data", rsp_data, 32'h700);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // ---------------- valid dropped during BUSY
      req0_valid = 1'b1; req0_op = 3'd4; a0 = 32'h1234;
      tick();
      chk("t6_ctl", {31'd0, mux_ctl}, 32'd0);
      req0_valid = 1'b0;
      tick(); tick();
      chk("t6_rdy0", {31'd0, req0_ready}, 32'd1);
      chk("t6_rv", {31'd0, rsp_valid}, 32'd1);
      chk("t6_id", {31'd0, rsp_id}, 32'd0);
      chk("t6_data", rsp_data, 32'h1234);
      tick();
      chk("t6_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("t6_no_regrant", {31'd0, busy}, 32'd0);

      // ---------------- LATENCY=1 instance
      l_req0_valid = 1'b1; l_req0_op = 3'd5; l_a0 = 32'h55AA;
      tick();
      chk("t5_ctl", {31'd0, l_mux_ctl}, 32'd0);
      chk("t5_op", {29'd0, l_alu_op}, 32'd5);
      chk("t5_busy", {31'd0, l_busy}, 32'd1);
      chk("t5_rv_c1", {31'd0, l_rsp_valid}, 32'd0);
      tick();
      chk("t5_rv", {31'd0, l_rsp_valid}, 32'd1);
      chk("t5_rdy0", {31'd0, l_req0_ready}, 32'd1);
      chk("t5_data", l_rsp_data, 32'h55AA);
      l_req0_valid = 1'b0; l_a0 = 32'hDEAD;
      tick();
      chk("t5_rv_off", {31'd0, l_rsp_valid}, 32'd0);
      chk("t5_busy_off", {31'd0, l_busy}, 32'd0);
      chk("t5_data_hold", l_rsp_data, 32'h55AA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
